// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a synchronous JK-flip-flop counter bank: optional
// parallel load followed by N up/down steps, with wrap detection and abort.
module counter_seq_ctrl #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_load,
   input  logic [WIDTH-1:0] cmd_load_val,
   input  logic             abort,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             wrap,
   output logic             done,
   output logic             aborted
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state;
   logic               r_dir;
   logic [WIDTH-1:0]   r_load_val;
   logic [LEN_W-1:0]   r_rem;
   logic               r_aborted;

   logic [WIDTH-1:0]   w_tog;
   logic               w_up_acc;
   logic               w_dn_acc;

   // Command sequencing; abort freezes rem and forces a qualified DONE
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_state    <= S_IDLE;
         r_dir      <= 1'b0;
         r_load_val <= '0;
         r_rem      <= '0;
         r_aborted  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_dir      <= cmd_dir;
                  r_load_val <= cmd_load_val;
                  r_rem      <= cmd_len;
                  if (cmd_load)
                     r_state <= S_LOAD;
                  else if (cmd_len != '0)
                     r_state <= S_RUN;
                  else
                     r_state <= S_DONE;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  r_aborted <= 1'b1;
                  r_state   <= S_DONE;
               end else if (r_rem != '0) begin
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_DONE;
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_aborted <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_rem <= r_rem - LEN_W'(1);
                  if (r_rem == LEN_W'(1))
                     r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_aborted <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Ripple of the AND-of-lower-stages terms; final accumulators give all-ones / all-zeros
   always_comb begin
      w_tog    = '0;
      w_up_acc = 1'b1;
      w_dn_acc = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
         w_tog[i] = r_dir ? w_up_acc : w_dn_acc;
         w_up_acc = w_up_acc & q[i];
         w_dn_acc = w_dn_acc & ~q[i];
      end
   end

   // J/K drive: load forces set/reset per stage, run toggles, abort gates everything
   always_comb begin
      j    = '0;
      k    = '0;
      wrap = 1'b0;
      if (!abort) begin
         case (r_state)
            S_LOAD: begin
               j = r_load_val;
               k = ~r_load_val;
            end
            S_RUN: begin
               j    = w_tog;
               k    = w_tog;
               wrap = r_dir ? w_up_acc : w_dn_acc;
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign aborted   = (r_state == S_DONE) & r_aborted;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: JK counter plant, command-level reference model,
// scoreboard queue popped by a monitor on every done pulse.
module tb_counter_seq_ctrl;

   localparam int unsigned W     = 2;
   localparam int unsigned LEN_W = 8;
   localparam int          MOD   = 1 << W;
   localparam int          MAXV  = MOD - 1;

   logic             clk = 1'b0;
   logic             clear;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_dir;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_load;
   logic [W-1:0]     cmd_load_val;
   logic             abort;
   logic [W-1:0]     q_plant;
   logic [W-1:0]     j;
   logic [W-1:0]     k;
   logic             busy;
   logic             wrap;
   logic             done;
   logic             aborted;

   logic             set_en;
   logic [W-1:0]     set_val;

   typedef struct {
      int done_cyc;
      int q_fin;
      bit abrt;
      int wraps;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_cmp    = 0;
   int   n_fail   = 0;
   int   wrap_acc = 0;

   counter_seq_ctrl #(.WIDTH(W), .LEN_W(LEN_W)) dut (
      .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_load(cmd_load),
      .cmd_load_val(cmd_load_val), .abort(abort), .q(q_plant), .j(j), .k(k),
      .busy(busy), .wrap(wrap), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // JK counter bank; set_en models an external preset of the bank
   always @(posedge clk) begin
      if (set_en) q_plant <= set_val;
      else begin
         for (int i = 0; i < int'(W); i++) begin
            case ({j[i], k[i]})
               2'b10:   q_plant[i] <= 1'b1;
               2'b01:   q_plant[i] <= 1'b0;
               2'b11:   q_plant[i] <= ~q_plant[i];
               default: ;
            endcase
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp_v, $time);
      end
   endtask

   // Command-level model: ops are load then len steps, one per cycle after accept;
   // abort in cycle a suppresses op a onward and done follows in cycle a+1.
   function automatic exp_t model(input int q0, input bit d, input int len, input bit ld,
                                  input int lv, input int a, input int now);
      exp_t e;
      int   nops;
      int   perf;
      int   qv;
      bit   ab;
      nops    = len + (ld ? 1 : 0);
      ab      = (a >= 1) && (a <= nops);
      perf    = ab ? a - 1 : nops;
      qv      = q0;
      e.wraps = 0;
      for (int op = 1; op <= perf; op++) begin
         if (ld && op == 1) qv = lv;
         else if (d) begin
            if (qv == MAXV) e.wraps++;
            qv = (qv + 1) % MOD;
         end else begin
            if (qv == 0) e.wraps++;
            qv = (qv + MOD - 1) % MOD;
         end
      end
      e.q_fin    = qv;
      e.abrt     = ab;
      e.done_cyc = now + (ab ? a + 1 : nops + 1);
      return e;
   endfunction

   // Monitor: pops one expectation per done pulse
   always @(negedge clk) begin
      exp_t e;
      if (!clear) wrap_acc = 0;
      else begin
         check("aborted_without_done", int'(aborted & ~done), 0);
         if (wrap) wrap_acc++;
         if (done) begin
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
               e = sb.pop_front();
               check("done_cycle", cyc, e.done_cyc);
               check("aborted_flag", int'(aborted), int'(e.abrt));
               check("q_final", int'(q_plant), e.q_fin);
               check("wrap_count", wrap_acc, e.wraps);
               check("busy_in_done", int'(busy), 1);
               check("ready_in_done", int'(cmd_ready), 0);
               check("jk_in_done", int'(j | k), 0);
            end
            wrap_acc = 0;
         end
      end
   end

   task automatic issue(input bit d, input int len, input bit ld, input int lv,
                        input int a, input bit keep);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      cmd_dir      = d;
      cmd_len      = LEN_W'(len);
      cmd_load     = ld;
      cmd_load_val = W'(lv);
      cmd_valid    = 1'b1;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge clk);
         if (cmd_ready) begin
            sb.push_back(model(int'(q_plant), d, len, ld, lv, a, cyc));
            got = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!got) check("accept_timeout", 0, 1);
      if (!keep) cmd_valid = 1'b0;
      if (got && a > 0) begin
         repeat (a - 1) @(posedge clk);
         #1 abort = 1'b1;
         @(posedge clk); #1 abort = 1'b0;
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge clk);
      check("drain_outstanding", sb.size(), 0);
   endtask

   task automatic set_q(input int v);
      @(posedge clk); #1;
      set_val = W'(v);
      set_en  = 1'b1;
      @(posedge clk); #1;
      set_en  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},   int'(cmd_ready), 1);
      check({tag, "_busy"},    int'(busy), 0);
      check({tag, "_done"},    int'(done), 0);
      check({tag, "_aborted"}, int'(aborted), 0);
      check({tag, "_j"},       int'(j), 0);
      check({tag, "_k"},       int'(k), 0);
      check({tag, "_wrap"},    int'(wrap), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int up_exp[5];
      int dn_exp[4];
      int len;
      int a;
      bit ld;
      up_exp = '{1, 2, 3, 0, 1};
      dn_exp = '{2, 1, 0, 3};

      clear = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = '0;
      cmd_load = 1'b0; cmd_load_val = '0; abort = 1'b0;
      set_en = 1'b1; set_val = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      set_en = 1'b0;
      clear  = 1'b1;

      // Up count of 5 from 0
      set_q(0);
      issue(1'b1, 5, 1'b0, 0, 0, 1'b0);
      for (int s = 0; s < 5; s++) begin
         @(posedge clk); @(negedge clk);
         check("up_seq_q", int'(q_plant), up_exp[s]);
      end
      drain();

      // Load 2 then down count of 3
      issue(1'b0, 3, 1'b1, 2, 0, 1'b0);
      for (int s = 0; s < 4; s++) begin
         @(posedge clk); @(negedge clk);
         check("down_seq_q", int'(q_plant), dn_exp[s]);
      end
      drain();

      // Zero length, then load-only of 3
      issue(1'b1, 0, 1'b0, 0, 0, 1'b0);
      issue(1'b1, 0, 1'b1, 3, 0, 1'b0);
      drain();
      check("load_only_q", int'(q_plant), 3);

      // Abort during step 2 of a 10-step up run from 0
      set_q(0);
      issue(1'b1, 10, 1'b0, 0, 2, 1'b0);
      drain();
      check("abort_hold_q", int'(q_plant), 1);

      // Reset asserted mid-run: immediate reset outputs, no done
      issue(1'b1, 10, 1'b0, 0, 0, 1'b0);
      repeat (3) @(posedge clk);
      #2 clear = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      sb.delete();
      @(posedge clk); #1 clear = 1'b1;
      @(negedge clk);
      check("ready_after_reset", int'(cmd_ready), 1);
      repeat (12) @(posedge clk);

      // Randomized commands with gaps, random presets and occasional aborts
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            drain();
            set_q(int'($urandom_range(0, MAXV)));
         end
         len = int'($urandom_range(0, 12));
         ld  = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 3) == 0) ?
               int'($urandom_range(1, len + (ld ? 1 : 0) + 1)) : 0;
         issue(1'($urandom_range(0, 1)), len, ld, int'($urandom_range(0, MAXV)), a, 1'b0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain();

      // Back-to-back with cmd_valid held high throughout
      for (int n = 0; n < 12; n++) begin
         len = int'($urandom_range(0, 6));
         ld  = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 4) == 0) ?
               int'($urandom_range(1, len + (ld ? 1 : 0) + 1)) : 0;
         issue(1'($urandom_range(0, 1)), len, ld, int'($urandom_range(0, MAXV)), a,
               (n != 11));
      end
      drain();
      repeat (5) @(posedge clk);
      check("final_outstanding", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencing controller for the team's synchronous JK-flip-flop counter bank (WIDTH stages of jkff sharing one clock). It accepts commands over a valid/ready handshake: an optional parallel load, then a run of N up or down steps. For every clock it drives the per-stage J/K inputs, using the counter's Q outputs as feedback. It pulses `done` on completion, so a higher-level CPU/timer FSM can use the counter as a managed resource.

## Interface
- `WIDTH`, 2: number of JK stages controlled (1..8).
- `LEN_W`, 8: width of step-count field.
- `clk`  in  1  single system clock, rising edge; same clock as counter bank.
- `clear`  in  1  reset, asynchronous, active-low; low forces controller to reset state immediately.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept; high only in IDLE.
- `cmd_dir`  in  1  1 = count up, 0 = count down.
- `cmd_len`  in  LEN_W  number of count steps (0 allowed).
- `cmd_load`  in  1  perform parallel load before counting.
- `cmd_load_val`  in  WIDTH  value to load.
- `abort`  in  1  synchronous stop request.
- `q`  in  WIDTH  Q feedback from counter stages (bit 0 = LSB).
- `j`  out  WIDTH  J inputs to counter stages.
- `k`  out  WIDTH  K inputs to counter stages.
- `busy`  out  1  high in LOAD, RUN, DONE.
- `wrap`  out  1  high in a RUN cycle whose step wraps the counter.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  qualifies `done`: run ended by `abort`.

## Operation
- States: IDLE, LOAD, RUN, DONE; state and registers are 2-bit encoded or one-hot, at implementer's choice.
- Registers: `dir_r`, `load_val_r`, `rem` (LEN_W), `aborted_r`.
- IDLE:
  - `cmd_ready` = 1.
  - On `cmd_valid`, capture `dir_r`, `load_val_r`, and `rem` = `cmd_len`.
  - Next state: LOAD if `cmd_load`; else RUN if `cmd_len` != 0; else DONE.
- LOAD (one cycle):
  - `j[i]` = `load_val_r[i]`, `k[i]` = ~`load_val_r[i]`.
  - Next state: RUN if `rem` != 0, else DONE.
- RUN, up count:
  - `j[i]` = `k[i]` = AND of `q[i-1:0]`; stage 0 always toggles.
  - `wrap` = (`q` == all ones).
- RUN, down count:
  - `j[i]` = `k[i]` = AND of ~`q[i-1:0]`.
  - `wrap` = (`q` == 0).
- RUN, every cycle: `rem` decrements. When `rem` == 1, next state is DONE.
- DONE:
  - `done` = 1, `aborted` = `aborted_r`.
  - Next state IDLE; `aborted_r` is cleared on leaving DONE.
- Outside LOAD and RUN, `j` = `k` = 0 (counter holds).
- `abort`:
  - Sampled in LOAD or RUN.
  - In that cycle, `j` = `k` = 0 and `wrap` = 0 (combinational gating); the step or load is suppressed.
  - `rem` is frozen, `aborted_r` is set, and next state is DONE.
  - Ignored in IDLE and DONE.
- `j`, `k`, and `wrap` are combinational from state, registers and `q`. All other outputs decode state only.

## Timing
- Reset (`clear` low, asynchronous): state = IDLE, `rem` = 0, `aborted_r` = 0.
  - Output values: `cmd_ready` = 1, `busy` = 0, `done` = 0, `aborted` = 0, `j` = `k` = 0, `wrap` = 0.
- Reset asserted mid-operation aborts silently: no `done` pulse. Counter bank state is not touched by the controller.
- Handshake: transfer on a rising edge with `cmd_valid` & `cmd_ready`. Command fields need only be stable at that edge.
- Timeline, with the accept edge called E0:
  - Load, if requested, takes effect at E1.
  - Steps take effect at the following `cmd_len` edges.
  - `done` is high for exactly one cycle, after the last step or load edge.
  - `cmd_ready` returns the cycle after `done`.
- Minimum command spacing is accept-to-accept = `cmd_len` + `cmd_load` + 2 cycles.
- `cmd_len` = 0 with no load: `done` is high in the cycle after E0, and `q` is unchanged.
- Wrap-around is modular with no saturation. `wrap` may assert on several steps of one run.

## Test plan
- Reset: drive `clear` low mid-RUN. Required: outputs immediately at reset values and no `done`. After release, `cmd_ready` = 1.
- Up count, WIDTH = 2, `q` = 0, `cmd_len` = 5, no load. Required:
  - `q` after successive edges = 1, 2, 3, 0, 1.
  - `wrap` high only in the RUN cycle where `q` = 3.
  - `done` high one cycle, 6 cycles after accept.
- Load 2 then down count, `cmd_len` = 3. Required: `q` = 2, 1, 0, 3; `wrap` high once, in the cycle where `q` = 0; `done` pulses with `aborted` = 0.
- Zero-length and load-only commands:
  - `cmd_len` = 0, no load: `done` the cycle after accept, `q` unchanged.
  - `cmd_len` = 0 with load value 3: `q` = 3, then `done`.
- Abort during step 2 of a `cmd_len` = 10 up run from 0. Required:
  - `q` holds at 1 through the abort cycle.
  - `done` and `aborted` both high the next cycle; IDLE after that.
- Back-to-back: hold `cmd_valid` high continuously. Required: commands accepted only in IDLE cycles, with no command lost or duplicated.
